pong_round_ctrl: RTL and testbench

//  Game-round sequencer for the Pong playfield. Owns the ball position and motion, the score,
//  and the serve/play/score/game-over flow. Updates once per video frame. Its BallX/BallY feed
//  the object hit-test blocks that the VGA scan polls.

---
 rtl/pong_pkg.sv | 53 +++++
 rtl/pong_ball_step.sv | 123 ++++++++++++
 rtl/pong_round_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pong_round_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pong_pkg
// Description : Shared state encodings, playfield geometry and winner codes
//               for the Pong round sequencer and its ball stepper.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Round flow states; encodings 5-7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_SCORED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Playfield geometry in pixels.
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_H    = 64;
  localparam int LEFT_PAD_X  = 16;
  localparam int RIGHT_PAD_X = 616;
  localparam int BALL_SPEED  = 2;

  // Ball rest position and bounce stops in native output widths.
  localparam logic [9:0] CENTRE_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0] CENTRE_Y   = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [8:0] MAX_Y      = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] LEFT_STOP  = 10'(LEFT_PAD_X + PADDLE_W);
  localparam logic [9:0] RIGHT_STOP = 10'(RIGHT_PAD_X - BALL_SIZE);
  localparam logic [9:0] STEP_X     = 10'(BALL_SPEED);
  localparam logic [8:0] STEP_Y     = 9'(BALL_SPEED);

  // 11-bit copies so that sums used in comparisons never wrap.
  localparam logic [10:0] W_SPEED      = 11'(BALL_SPEED);
  localparam logic [10:0] W_SIZE       = 11'(BALL_SIZE);
  localparam logic [10:0] W_PAD_H      = 11'(PADDLE_H);
  localparam logic [10:0] W_SCREEN_W   = 11'(SCREEN_W);
  localparam logic [10:0] W_SCREEN_H   = 11'(SCREEN_H);
  localparam logic [10:0] W_LEFT_STOP  = 11'(LEFT_PAD_X + PADDLE_W);
  localparam logic [10:0] W_RIGHT_STOP = 11'(RIGHT_PAD_X - BALL_SIZE);

  // Winner output codes.
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_ball_step.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_step
// Description : Registered ball position and direction. Moves one step per
//               enabled frame, bounces off the top/bottom walls and paddles,
//               and flags a miss when the ball leaves the left or right side.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_ball_step
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,            // advance one frame (PLAY frame_tick)
  input  logic       centre,          // park the ball at the centre
  input  logic       load_dx,         // load the serve direction
  input  logic       serve_dx,        // 1 = right, 0 = left
  input  logic       toggle_dy,       // flip vertical direction for the next serve
  input  logic [8:0] left_paddle_y,
  input  logic [8:0] right_paddle_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [1:0] miss             // [0] left side (right scores), [1] right side (left scores)
);

  logic        dx;                    // 1 = moving right
  logic        dy;                    // 1 = moving down
  logic [9:0]  x_next;
  logic [8:0]  y_next;
  logic        dx_next;
  logic        dy_next;
  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] lp_w;
  logic [10:0] rp_w;
  logic        hit_l;
  logic        hit_r;
  logic        out_l;
  logic        out_r;

  assign x_w  = {1'b0, ball_x};
  assign y_w  = {2'b00, ball_y};
  assign lp_w = {2'b00, left_paddle_y};
  assign rp_w = {2'b00, right_paddle_y};

  // The left test is written as x <= stop+speed so a ball near x=0 cannot underflow.
  assign hit_l = (x_w <= W_LEFT_STOP + W_SPEED) && (x_w >= W_LEFT_STOP) &&
                 (y_w + W_SIZE > lp_w) && (y_w < lp_w + W_PAD_H);
  assign hit_r = (x_w + W_SPEED >= W_RIGHT_STOP) && (x_w <= W_RIGHT_STOP) &&
                 (y_w + W_SIZE > rp_w) && (y_w < rp_w + W_PAD_H);
  assign out_l = (x_w < W_SPEED);
  assign out_r = (x_w + W_SIZE + W_SPEED > W_SCREEN_W);

  // A paddle hit takes priority over leaving the field.
  assign miss[0] = !dx && !hit_l && out_l;
  assign miss[1] =  dx && !hit_r && out_r;

  // Next position/direction: serve set-up first, then one frame of motion.
  always_comb begin
    x_next  = ball_x;
    y_next  = ball_y;
    dx_next = dx;
    dy_next = dy;
    if (centre) begin
      x_next = CENTRE_X;
      y_next = CENTRE_Y;
    end
    if (load_dx) begin
      dx_next = serve_dx;
    end
    if (toggle_dy) begin
      dy_next = ~dy;
    end
    if (step) begin
      if (dy) begin
        if (y_w + W_SIZE + W_SPEED >= W_SCREEN_H) begin
          y_next  = MAX_Y;
          dy_next = 1'b0;
        end else begin
          y_next = ball_y + STEP_Y;
        end
      end else if (y_w < W_SPEED) begin
        y_next  = '0;
        dy_next = 1'b1;
      end else begin
        y_next = ball_y - STEP_Y;
      end

      if (dx) begin
        if (hit_r) begin
          x_next  = RIGHT_STOP;
          dx_next = 1'b0;
        end else if (!out_r) begin
          x_next = ball_x + STEP_X;
        end
      end else begin
        if (hit_l) begin
          x_next  = LEFT_STOP;
          dx_next = 1'b1;
        end else if (!out_l) begin
          x_next = ball_x - STEP_X;
        end
      end
    end
  end

  // Ball state registers; reset parks the ball at the centre heading down-right.
  always_ff @(posedge clk) begin
    if (reset) begin
      ball_x <= CENTRE_X;
      ball_y <= CENTRE_Y;
      dx     <= 1'b1;
      dy     <= 1'b1;
    end else begin
      ball_x <= x_next;
      ball_y <= y_next;
      dx     <= dx_next;
      dy     <= dy_next;
    end
  end

endmodule : pong_ball_step
`default_nettype wire

// File: rtl/pong_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_round_ctrl
// Description : Pong round sequencer. Runs IDLE/SERVE/PLAY/SCORED/OVER once
//               per video frame, keeps both scores and the winner, and drives
//               the ball stepper.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_round_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [8:0] LeftPaddleY,
  input  logic [8:0] RightPaddleY,
  output logic [9:0] BallX,
  output logic [8:0] BallY,
  output logic       BallVisible,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR,
  output logic [2:0] State,
  output logic [1:0] Winner
);

  localparam int                CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]        WIN_PTS    = 4'(WIN_SCORE);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       score_l_n;
  logic [3:0]       score_r_n;
  logic [3:0]       inc_l;
  logic [3:0]       inc_r;
  logic [1:0]       winner_n;
  logic             scorer_left;       // who won the last point
  logic             scorer_left_n;
  logic             visible_n;
  logic             step;
  logic             centre;
  logic             load_dx;
  logic             serve_dx;
  logic             toggle_dy;
  logic [1:0]       miss;

  assign inc_l = ScoreL + 4'd1;
  assign inc_r = ScoreR + 4'd1;
  assign State = state;

  pong_ball_step u_ball (
    .clk            (clk),
    .reset          (reset),
    .step           (step),
    .centre         (centre),
    .load_dx        (load_dx),
    .serve_dx       (serve_dx),
    .toggle_dy      (toggle_dy),
    .left_paddle_y  (LeftPaddleY),
    .right_paddle_y (RightPaddleY),
    .ball_x         (BallX),
    .ball_y         (BallY),
    .miss           (miss)
  );

  // Round flow: next state, serve counter, scores and ball commands.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    score_l_n     = ScoreL;
    score_r_n     = ScoreR;
    winner_n      = Winner;
    scorer_left_n = scorer_left;
    step          = 1'b0;
    centre        = 1'b0;
    load_dx       = 1'b0;
    serve_dx      = 1'b1;
    toggle_dy     = 1'b0;
    case (state)
      ST_IDLE: begin
        centre = 1'b1;
        if (start) begin
          state_n = ST_SERVE;
          cnt_n   = '0;
        end
      end
      ST_SERVE: begin
        centre = 1'b1;
        if (frame_tick) begin
          if (cnt == SERVE_LAST) begin
            state_n = ST_PLAY;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        step = frame_tick;
        if (frame_tick && (miss != 2'b00)) begin
          state_n       = ST_SCORED;
          scorer_left_n = miss[1];
        end
      end
      ST_SCORED: begin
        if (frame_tick) begin
          // Recentre and aim the next serve at the player who lost the point.
          centre    = 1'b1;
          load_dx   = 1'b1;
          serve_dx  = scorer_left;
          toggle_dy = 1'b1;
          cnt_n     = '0;
          state_n   = ST_SERVE;
          if (scorer_left) begin
            score_l_n = inc_l;
            if (inc_l == WIN_PTS) begin
              state_n  = ST_OVER;
              winner_n = WIN_LEFT;
            end
          end else begin
            score_r_n = inc_r;
            if (inc_r == WIN_PTS) begin
              state_n  = ST_OVER;
              winner_n = WIN_RIGHT;
            end
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          state_n   = ST_SERVE;
          cnt_n     = '0;
          score_l_n = '0;
          score_r_n = '0;
          winner_n  = WIN_NONE;
          centre    = 1'b1;
          load_dx   = 1'b1;
          serve_dx  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    visible_n = (state_n == ST_SERVE) || (state_n == ST_PLAY);
  end

  // Round state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ScoreL      <= '0;
      ScoreR      <= '0;
      Winner      <= WIN_NONE;
      scorer_left <= 1'b0;
      BallVisible <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ScoreL      <= score_l_n;
      ScoreR      <= score_r_n;
      Winner      <= winner_n;
      scorer_left <= scorer_left_n;
      BallVisible <= visible_n;
    end
  end

endmodule : pong_round_ctrl
`default_nettype wire

// File: tb/tb_pong_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_round_ctrl
// Description : Directed bench for pong_round_ctrl. Plays a scripted rally
//               with known paddle positions and checks ball, score and state
//               against hand-computed values at chosen frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [8:0] LeftPaddleY;
  logic [8:0] RightPaddleY;
  logic [9:0] BallX;
  logic [8:0] BallY;
  logic       BallVisible;
  logic [3:0] ScoreL;
  logic [3:0] ScoreR;
  logic [2:0] State;
  logic [1:0] Winner;

  int total = 0;
  int bad   = 0;
  int p     = 0;   // frames elapsed in the current PLAY phase

  pong_round_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .LeftPaddleY  (LeftPaddleY),
    .RightPaddleY (RightPaddleY),
    .BallX        (BallX),
    .BallY        (BallY),
    .BallVisible  (BallVisible),
    .ScoreL       (ScoreL),
    .ScoreR       (ScoreR),
    .State        (State),
    .Winner       (Winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Each frame: tick high for one cycle, low for one; returns on a falling edge.
  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
    end
  endtask

  task automatic adv(input int target);
    ticks(target - p);
    p = target;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"},   BallX, 316);
    check({tag, "_y"},   BallY, 236);
    check({tag, "_vis"}, BallVisible, 0);
    check({tag, "_sl"},  ScoreL, 0);
    check({tag, "_sr"},  ScoreR, 0);
    check({tag, "_st"},  State, 0);
    check({tag, "_win"}, Winner, 0);
  endtask

  initial begin
    reset        = 1'b1;
    frame_tick   = 1'b0;
    start        = 1'b0;
    LeftPaddleY  = 9'd140;
    RightPaddleY = 9'd380;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("rst");

    // Ticks alone do nothing in IDLE.
    ticks(3);
    check("idle_hold", State, 0);

    // Start together with a tick: that tick is not counted.
    @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
    check("serve_st", State, 1);
    check("serve_vis", BallVisible, 1);

    // start mid-serve is ignored; 59 ticks still SERVE, 60th enters PLAY.
    ticks(30);
    pulse_start();
    ticks(29);
    check("serve_59", State, 1);
    ticks(1);
    check("play_st", State, 2);
    check("play_x0", BallX, 316);
    check("play_y0", BallY, 236);

    // Diagonal motion, bottom bounce, right paddle hit (RightPaddleY=380).
    adv(1);   check("p1_x", BallX, 318); check("p1_y", BallY, 238);
    adv(117); check("p117_y", BallY, 470); check("p117_x", BallX, 550);
    adv(118); check("p118_y", BallY, 472);
    adv(119); check("p119_y", BallY, 470);
    adv(145); check("p145_x", BallX, 606); check("p145_y", BallY, 418);
    adv(146); check("p146_x", BallX, 608); check("p146_y", BallY, 416);
    adv(147); check("p147_x", BallX, 606);

    // Top wall: 2 -> 0, then held at 0 for the turnaround frame.
    adv(354); check("p354_y", BallY, 0); check("p354_x", BallX, 192);
    adv(355); check("p355_y", BallY, 0); check("p355_x", BallX, 190);
    adv(356); check("p356_y", BallY, 2);

    // Left paddle hit (LeftPaddleY=140) snaps to x=24 and reverses.
    adv(437); check("p437_x", BallX, 26); check("p437_y", BallY, 164);
    adv(438); check("p438_x", BallX, 24); check("p438_y", BallY, 166);
    check("p438_sr", ScoreR, 0); check("p438_st", State, 2);
    adv(439); check("p439_x", BallX, 26);

    // Right paddle moved to 160 to return the ball; left paddle out of reach.
    LeftPaddleY  = 9'd500;
    RightPaddleY = 9'd160;
    adv(729); check("p729_x", BallX, 606); check("p729_y", BallY, 196);
    adv(730); check("p730_x", BallX, 608); check("p730_y", BallY, 194);
    adv(731); check("p731_x", BallX, 606);

    // Left miss: right scores.
    adv(1033); check("p1033_x", BallX, 2);
    adv(1034); check("p1034_x", BallX, 0); check("p1034_st", State, 2);
    adv(1035); check("scored_st", State, 3); check("scored_sr", ScoreR, 0);
    pulse_start();
    check("scored_start_ign", State, 3);
    adv(1036);
    check("pt_sr", ScoreR, 1); check("pt_sl", ScoreL, 0); check("pt_st", State, 1);
    check("pt_x", BallX, 316); check("pt_y", BallY, 236); check("pt_vis", BallVisible, 1);

    // Serve after a right point heads left.
    ticks(60);
    check("serve2_st", State, 2);
    ticks(1);
    check("serve2_x", BallX, 314);

    // Reset mid-PLAY returns everything to reset values.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_reset_vals("midrst");

    // Game 2: no paddles in reach; left wins 7-0 on right-side misses.
    LeftPaddleY  = 9'd500;
    RightPaddleY = 9'd500;
    pulse_start();
    check("g2_st", State, 1);
    for (int k = 1; k <= 7; k++) begin
      ticks(60);
      check($sformatf("g2_play%0d", k), State, 2);
      ticks(158);
      check($sformatf("g2_edge%0d", k), BallX, 632);
      ticks(1);
      check($sformatf("g2_scored%0d", k), State, 3);
      ticks(1);
      check($sformatf("g2_sl%0d", k), ScoreL, k);
      check($sformatf("g2_st%0d", k), State, (k < 7) ? 1 : 4);
      check($sformatf("g2_win%0d", k), Winner, (k < 7) ? 0 : 1);
      check($sformatf("g2_vis%0d", k), BallVisible, (k < 7) ? 1 : 0);
    end
    check("g2_sr", ScoreR, 0);

    // OVER holds until start, which clears scores and serves right.
    ticks(3);
    check("over_hold_st", State, 4);
    check("over_hold_sl", ScoreL, 7);
    pulse_start();
    check("restart_st", State, 1);
    check("restart_sl", ScoreL, 0);
    check("restart_win", Winner, 0);
    check("restart_vis", BallVisible, 1);
    ticks(60);
    check("restart_play", State, 2);
    ticks(1);
    check("restart_x", BallX, 318);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pong_round_ctrl
`default_nettype wire
